// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write path.
// Contents: register index / data word typedefs, the write request
// payload carried through the UART FIFO, and the grant source enum.
package regfile_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_idx_t rw;
    logic     fp;
    word_t    data;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_UART = 2'd2
  } src_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the write sources, the arbiter and the register file.
// master : the side that offers writes and observes the register-file fields
// slave  : the arbiter
// Signals: wb_* (pipeline writeback + stall), uart_* (UART load offer/ready),
//          rf_* (registered write fields + toggle token), fifo_count.
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
) ();
  import regfile_pkg::*;

  logic                    wb_valid;
  reg_idx_t                wb_rw;
  logic                    wb_fp;
  word_t                   wb_data;
  logic                    wb_stall;

  logic                    uart_valid;
  logic                    uart_ready;
  reg_idx_t                uart_rw;
  logic                    uart_fp;
  word_t                   uart_data;

  logic                    rf_regwrite;
  logic                    rf_uart_we;
  reg_idx_t                rf_rw;
  logic                    rf_fp;
  word_t                   rf_data;
  logic                    rf_distinct;

  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output wb_valid, wb_rw, wb_fp, wb_data,
    output uart_valid, uart_rw, uart_fp, uart_data,
    input  wb_stall, uart_ready,
    input  rf_regwrite, rf_uart_we, rf_rw, rf_fp, rf_data, rf_distinct,
    input  fifo_count
  );

  modport slave (
    input  wb_valid, wb_rw, wb_fp, wb_data,
    input  uart_valid, uart_rw, uart_fp, uart_data,
    output wb_stall, uart_ready,
    output rf_regwrite, rf_uart_we, rf_rw, rf_fp, rf_data, rf_distinct,
    output fifo_count
  );

endinterface

// File: rtl/regfile_write_arbiter_uart_wr_fifo.sv
// Circular buffer holding pending UART register writes.
// Ports: CLK, reset (sync, active-high); push_valid/push_data/push_ready
// (push when valid && ready); pop (caller only pops when non-empty);
// head (oldest entry), empty, count (entries held).
// Ready is derived from the registered count only, so a pop while full does
// not admit a push in the same cycle, and a pushed entry is not visible at
// the head until the following cycle.
module uart_wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push_valid,
  input  rf_wr_req_t       push_data,
  output logic             push_ready,
  input  logic             pop,
  output rf_wr_req_t       head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  rf_wr_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];
  assign count      = count_q;

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file's single write port.
// Ports: CLK, reset (sync, active-high), bus (slave side of the arbiter bus).
// Pipeline writeback wins by default; UART writes queue in a FIFO and get a
// forced slot after STARVE_LIMIT consecutive writeback wins while queued.
// Every issued write flips rf_distinct; the register file writes whenever the
// token differs from its own buffered copy, so holding the token on idle
// cycles prevents duplicate writes.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int UART_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input logic                   CLK,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int         CNT_W      = $clog2(UART_FIFO_DEPTH) + 1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  rf_wr_req_t       wb_req;
  rf_wr_req_t       uart_req;
  rf_wr_req_t       fifo_head;
  logic             fifo_empty;
  logic             fifo_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             g_wb;
  logic             g_uart;
  src_t             grant_src;
  logic [3:0]       starve_cnt;

  assign wb_req   = '{rw: bus.wb_rw,   fp: bus.wb_fp,   data: bus.wb_data};
  assign uart_req = '{rw: bus.uart_rw, fp: bus.uart_fp, data: bus.uart_data};

  always_comb begin
    g_uart    = !fifo_empty && (!bus.wb_valid || (starve_cnt == STARVE_MAX));
    g_wb      = bus.wb_valid && !g_uart;
    grant_src = SRC_NONE;
    if (g_uart)    grant_src = SRC_UART;
    else if (g_wb) grant_src = SRC_WB;
  end

  assign bus.wb_stall   = bus.wb_valid && g_uart;
  assign bus.uart_ready = fifo_ready;
  assign bus.fifo_count = fifo_count;

  uart_wr_fifo #(
    .DEPTH (UART_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .CLK        (CLK),
    .reset      (reset),
    .push_valid (bus.uart_valid),
    .push_data  (uart_req),
    .push_ready (fifo_ready),
    .pop        (g_uart),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Counts writeback wins only while a UART write is actually waiting.
  always_ff @(posedge CLK) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (g_uart || fifo_empty) begin
      starve_cnt <= '0;
    end else if (g_wb && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Token resets to 1 to match the register file's reset buffer.
  always_ff @(posedge CLK) begin
    if (reset) begin
      bus.rf_regwrite <= 1'b0;
      bus.rf_uart_we  <= 1'b0;
      bus.rf_rw       <= '0;
      bus.rf_fp       <= 1'b0;
      bus.rf_data     <= '0;
      bus.rf_distinct <= 1'b1;
    end else begin
      case (grant_src)
        SRC_WB: begin
          bus.rf_regwrite <= 1'b1;
          bus.rf_uart_we  <= 1'b0;
          bus.rf_rw       <= wb_req.rw;
          bus.rf_fp       <= wb_req.fp;
          bus.rf_data     <= wb_req.data;
          bus.rf_distinct <= ~bus.rf_distinct;
        end
        SRC_UART: begin
          bus.rf_regwrite <= 1'b0;
          bus.rf_uart_we  <= 1'b1;
          bus.rf_rw       <= fifo_head.rw;
          bus.rf_fp       <= fifo_head.fp;
          bus.rf_data     <= fifo_head.data;
          bus.rf_distinct <= ~bus.rf_distinct;
        end
        default: begin
          bus.rf_regwrite <= 1'b0;
          bus.rf_uart_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
